// File: rtl/cc_pkg.sv
// Shared types and helpers for the condition-code unit: the N/Z/P triple,
// the "no flags" constant and the bus-value classifier.
package cc_pkg;

  // Widest bus the classifier accepts; callers extend their bus to this width.
  localparam int CC_MAX_W = 128;

  localparam logic [2:0] CC_NONE = 3'b000;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  // Classify a value that the caller has already extended to CC_MAX_W bits:
  // sign-extended in signed mode, zero-extended otherwise. Exactly one flag
  // is set in the result.
  function automatic cc_t cc_decode(input logic [CC_MAX_W-1:0] value,
                                    input logic                signed_mode);
    cc_t cc;
    cc = CC_NONE;
    if (signed_mode && value[CC_MAX_W-1]) begin
      cc.n = 1'b1;
    end else if (value == '0) begin
      cc.z = 1'b1;
    end else begin
      cc.p = 1'b1;
    end
    return cc;
  endfunction

endpackage

// File: rtl/cc_lifo.sv
// Hardware LIFO holding saved N/Z/P triples. Tracks occupancy, exposes the
// top entry, and flags (as single-cycle pulses) pushes into a full stack and
// pops from an empty one. Simultaneous push and pop is a no-op.
module cc_lifo
  import cc_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  cc_t           din,
  output cc_t           dout,
  output logic [DW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          udf
);

  // Sized to the full range of the occupancy counter so the counter can
  // address it directly; entries at or above DEPTH are never written.
  cc_t           mem [2**DW];
  logic [DW-1:0] cnt_q;
  logic          wr;
  logic          rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DW'(DEPTH));
  assign wr    = push & ~pop & ~full;
  assign rd    = pop & ~push & ~empty;
  assign ovf   = push & ~pop & full;
  assign udf   = pop & ~push & empty;
  assign depth = cnt_q;
  assign dout  = mem[cnt_q - DW'(1)];

  // Occupancy counter: up on an accepted push, down on an accepted pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (wr) begin
      cnt_q <= cnt_q + DW'(1);
    end else if (rd) begin
      cnt_q <= cnt_q - DW'(1);
    end
  end

  // Entry storage, written at the current occupancy on an accepted push.
  // NOTE: storage has no reset; an empty stack makes every entry don't-care,
  // and leaving it unreset lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[cnt_q] <= din;
    end
  end

endmodule

// File: rtl/cc_stack_unit.sv
// Condition-code unit: registered N/Z/P decoded from the bus, registered
// branch enable, a LIFO that saves/restores N/Z/P across interrupts, and
// sticky overflow/underflow error flags.
module cc_stack_unit
  import cc_pkg::*;
#(
  parameter int DATA_W = 16,  // 2..CC_MAX_W
  parameter int DEPTH  = 4,
  parameter int SIGNED = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Load,
  input  logic                         Load_Ben,
  input  logic [2:0]                   NZP,
  input  logic [DATA_W-1:0]            buslogic,
  input  logic                         Push,
  input  logic                         Pop,
  input  logic                         Clr_Err,
  output logic                         n,
  output logic                         z,
  output logic                         p,
  output logic                         BEN,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         empty,
  output logic                         full,
  output logic                         err_ovf,
  output logic                         err_udf
);

  localparam bit SIGNED_MODE = (SIGNED != 0);

  logic [CC_MAX_W-1:0] bus_ext;
  cc_t                 cc_q;
  cc_t                 cc_dec;
  cc_t                 cc_top;
  logic                ben_q;
  logic                ovf_q;
  logic                udf_q;
  logic                ovf_evt;
  logic                udf_evt;
  logic                restore;

  // Extending by signedness puts the bus MSB at the classifier's MSB in
  // signed mode and keeps it clear in unsigned mode.
  assign bus_ext = SIGNED_MODE ? CC_MAX_W'(signed'(buslogic)) : CC_MAX_W'(buslogic);
  assign cc_dec  = cc_decode(bus_ext, SIGNED_MODE);
  assign restore = Pop & ~Push & ~empty;

  cc_lifo #(
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (Push),
    .pop   (Pop),
    .din   (cc_q),
    .dout  (cc_top),
    .depth (depth),
    .empty (empty),
    .full  (full),
    .ovf   (ovf_evt),
    .udf   (udf_evt)
  );

  // Flag register: a restore from the stack takes priority over a bus load.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cc_q <= CC_NONE;
    end else if (restore) begin
      cc_q <= cc_top;
    end else if (Load) begin
      cc_q <= cc_dec;
    end
  end

  // Branch enable, always evaluated against the flags held before this edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ben_q <= 1'b0;
    end else if (Load_Ben) begin
      ben_q <= |(NZP & cc_q);
    end
  end

  // Sticky errors: a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_evt)      ovf_q <= 1'b1;
      else if (Clr_Err) ovf_q <= 1'b0;
      if (udf_evt)      udf_q <= 1'b1;
      else if (Clr_Err) udf_q <= 1'b0;
    end
  end

  assign n       = cc_q.n;
  assign z       = cc_q.z;
  assign p       = cc_q.p;
  assign BEN     = ben_q;
  assign err_ovf = ovf_q;
  assign err_udf = udf_q;

endmodule
